// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 lint arbiter: response record, error
// pattern and the bank address-range check.
package l2_arb_pkg;

  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  typedef logic [0:0] master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
    logic       err;
    logic       is_read;
  } resp_t;

  // Widened to 64 bits so the subtraction and compare never wrap for any ADDR_WIDTH <= 64.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                    input int unsigned mem_aw);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> (mem_aw + 2)) == 64'd0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the priority pointer moves to the other master
// after every grant and is untouched by cycles with no grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] eligible,
  output logic [1:0] gnt
);

  logic       prio;
  logic [1:0] cand;

  always_comb begin
    cand = req & eligible;
    gnt  = cand;
    if (cand == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n)      prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end

endmodule

// File: rtl/l2_lint_arbiter.sv
// Shares one single-port L2 SRAM bank between the debug bridge (master 0) and
// the system interconnect (master 1), with range checking and a 1-cycle response.
module l2_lint_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH     = 32,
  parameter int unsigned                DATA_WIDTH     = 32,
  parameter int unsigned                MEM_ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR      = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n,
  input  logic [1:0]                           m_req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]           m_addr_i,
  input  logic [1:0]                           m_wen_i,
  input  logic [1:0][3:0]                      m_be_i,
  input  logic [1:0][DATA_WIDTH-1:0]           m_wdata_i,
  output logic [1:0]                           m_gnt_o,
  output logic [1:0]                           m_r_valid_o,
  output logic [1:0][DATA_WIDTH-1:0]           m_r_rdata_o,
  output logic [1:0]                           m_r_opc_o,
  input  logic                                 dbg_excl_i,
  output logic                                 mem_csn_o,
  output logic                                 mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [3:0]                           mem_be_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  output logic [15:0]                          conflict_cnt_o
);

  logic [1:0]            eligible;
  logic [1:0]            gnt;
  logic                  any_gnt;
  logic                  hit;
  master_id_t            gnt_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] off;
  resp_t                 resp_d, resp_q;

  // Holding eligibility low during reset keeps grants and chip select quiet.
  assign eligible = {rst_n & ~dbg_excl_i, rst_n};

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .req      (m_req_i),
    .eligible (eligible),
    .gnt      (gnt)
  );

  assign any_gnt  = |gnt;
  assign gnt_id   = gnt[1];
  assign sel_addr = m_addr_i[gnt_id];
  assign off      = sel_addr - BASE_ADDR;
  assign hit      = in_range(64'(sel_addr), 64'(BASE_ADDR), MEM_ADDR_WIDTH);

  assign m_gnt_o     = gnt;
  assign mem_csn_o   = ~(any_gnt & hit);
  assign mem_wen_o   = m_wen_i[gnt_id];
  assign mem_addr_o  = MEM_ADDR_WIDTH'(off >> 2);
  assign mem_be_o    = m_be_i[gnt_id];
  assign mem_wdata_o = m_wdata_i[gnt_id];

  always_comb begin
    resp_d         = '0;
    resp_d.valid   = any_gnt;
    resp_d.id      = gnt_id;
    resp_d.err     = ~hit;
    resp_d.is_read = m_wen_i[gnt_id];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) resp_q <= '0;
    else        resp_q <= resp_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n)                                             conflict_cnt_o <= '0;
    else if (m_req_i == 2'b11 && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
  end

  always_comb begin
    m_r_valid_o = '0;
    m_r_opc_o   = '0;
    m_r_rdata_o = '0;
    for (int i = 0; i < 2; i++) begin
      if (resp_q.valid && resp_q.id == master_id_t'(i)) begin
        m_r_valid_o[i] = 1'b1;
        m_r_opc_o[i]   = resp_q.err;
        if (resp_q.err)          m_r_rdata_o[i] = DATA_WIDTH'(ERR_RDATA);
        else if (resp_q.is_read) m_r_rdata_o[i] = mem_rdata_i;
      end
    end
  end

endmodule

// File: doc/l2_lint_arbiter.md
Name: l2_lint_arbiter

Overview:
- Shares one single-port L2 SRAM bank between two PULP-lint masters: port 0 is the JTAG debug bridge (PULP TAP AXI/lint path) and port 1 is the system interconnect.
- Implements round-robin arbitration, address-range checking, and a one-cycle SRAM read pipeline with per-master response routing.
- Sits between the debug/system masters and the L2 bank macro, in the same clock domain as the L2.

Parameters:
- ADDR_WIDTH, 32, byte address width of the master ports.
- DATA_WIDTH, 32, data width; must be 32 in this revision.
- MEM_ADDR_WIDTH, 14, SRAM word-address width (bank size = 4*2^MEM_ADDR_WIDTH bytes).
- BASE_ADDR, 32'h0000_0000, byte base address of the bank.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_req_i  in  [1:0]  request, per master
- m_addr_i  in  [1:0][ADDR_WIDTH-1:0]  byte address
- m_wen_i  in  [1:0]  1 = read, 0 = write (PULP lint convention)
- m_be_i  in  [1:0][3:0]  byte enables
- m_wdata_i  in  [1:0][31:0]  write data
- m_gnt_o  out  [1:0]  grant; combinational from req
- m_r_valid_o  out  [1:0]  response valid
- m_r_rdata_o  out  [1:0][31:0]  read data
- m_r_opc_o  out  [1:0]  1 = error response
- dbg_excl_i  in  1  while high, only master 0 may be granted
- mem_csn_o  out  1  SRAM chip select, active low
- mem_wen_o  out  1  SRAM write enable, active low
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address
- mem_be_o  out  4  SRAM byte enables
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid one cycle after a read access
- conflict_cnt_o  out  16  saturating count of cycles in which both masters requested

Behaviour:
- Reset is synchronous active-low on rst_n.
  - On the clk_i edge with rst_n = 0: prio pointer ← 0, response register cleared, conflict_cnt_o ← 0.
  - Any in-flight r_valid is dropped and never issued.
- Outputs during and after reset:
  - m_r_valid_o = 0, m_r_opc_o = 0, m_r_rdata_o = 0.
  - m_gnt_o = 0 while rst_n = 0.
  - mem_csn_o = 1 when no master is granted.
- Arbitration (combinational, at most one grant per cycle):
  - One requester eligible → it is granted.
  - Both eligible → the master indicated by the prio pointer wins.
  - After any grant to master i, prio ← 1-i on the next edge.
  - dbg_excl_i = 1 → master 1 is never eligible; prio is unaffected by blocked cycles.
- Address decode on the granted request:
  - off = addr - BASE_ADDR. In range iff addr >= BASE_ADDR and off < 4*2^MEM_ADDR_WIDTH.
  - mem_addr_o = off[MEM_ADDR_WIDTH+1:2]; addr[1:0] is ignored.
  - In range: mem_csn_o = 0; mem_wen_o = m_wen_i; be and wdata pass through.
  - Out of range: request is still granted, mem_csn_o stays 1, and the response carries the error.
- Response pipeline: one register {valid, id, err, is_read}.
  - Exactly one cycle after a grant, m_r_valid_o[id] = 1 for one cycle.
  - Read in range: m_r_rdata_o[id] = mem_rdata_i, opc = 0.
  - Write in range: rdata = 0, opc = 0.
  - Error: rdata = 32'hBADACCE5, opc = 1.
  - The non-addressed master sees r_valid = 0 and rdata = 0.
- Throughput: one grant per cycle; back-to-back grants give back-to-back r_valid.
  - Responses are never stalled; masters must always accept r_valid.
- conflict_cnt_o: increments on each cycle with m_req_i = 2'b11, including cycles where dbg_excl_i blocks master 1. It saturates at 16'hFFFF.
- Simultaneous reset and grant: reset wins; no access is registered.
  - mem_csn_o is combinational and suppressed (1) while rst_n = 0.

Decomposition:
- Package l2_arb_pkg:
  - ERR_RDATA = 32'hBADACCE5.
  - typedef master_id_t (logic [0:0]).
  - typedef struct resp_t {valid, id, err, is_read}.
  - Helper function in_range(addr).
- Sub-module rr_arb2: 2-input round-robin arbiter with prio register, eligibility mask and one-hot grant output. It has the same clk_i/rst_n conventions.

Test Plan:
- **Reset:** rst_n low 3 cycles with m_req_i = 2'b11 → m_gnt_o = 0, mem_csn_o = 1, m_r_valid_o = 0, conflict_cnt_o = 0.
- **Single master R/W:** m0 writes 32'hABBAABBA to 0x0 with be = 4'hF, then reads 0x0.
  - Write: gnt same cycle, mem_wen_o = 0, mem_addr_o = 0.
  - Read: r_valid[0] one cycle after gnt, rdata = 32'hABBAABBA, opc = 0.
- **Contention:** both masters request continuously for 4 cycles after reset.
  - Grant sequence m0, m1, m0, m1.
  - r_valid alternates one cycle later.
  - conflict_cnt_o = 4.
- **Exclusive debug:** dbg_excl_i = 1, both requesting for 3 cycles → only m0 is granted; m_gnt_o[1] = 0 throughout.
  - Deassert dbg_excl_i → m1 is granted next, since prio = 1.
- **Out of range:** m1 reads 4*2^14 = 0x10000 → gnt = 1, mem_csn_o = 1; the next cycle gives r_valid[1] = 1, opc = 1, rdata = 32'hBADACCE5.
- **Reset mid-op:** m0 read granted, then rst_n low at the next edge → no r_valid issued; after release, prio = 0.
